// File: rtl/dcache_sram_nway.sv
// N-way set-associative line store with true-LRU ages, victim reporting and a
// write-back-and-invalidate flush walker that visits every entry in set*WAYS+way order.
module dcache_sram_nway #(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic [$clog2(SETS)-1:0]  set_i,
    input  logic [TAG_W-1:0]         tag_i,
    input  logic                     we_i,
    input  logic                     fill_i,
    input  logic                     dirty_i,
    input  logic [LINE_W-1:0]        data_i,
    output logic                     ready_o,
    output logic                     hit_o,
    output logic [$clog2(WAYS)-1:0]  hit_way_o,
    output logic [LINE_W-1:0]        data_o,
    output logic [$clog2(WAYS)-1:0]  victim_way_o,
    output logic                     victim_valid_o,
    output logic                     victim_dirty_o,
    output logic [TAG_W-1:0]         victim_tag_o,
    output logic [LINE_W-1:0]        victim_data_o,
    input  logic                     flush_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [$clog2(SETS)-1:0]  wb_set_o,
    output logic [TAG_W-1:0]         wb_tag_o,
    output logic [LINE_W-1:0]        wb_data_o,
    output logic                     flush_done_o
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);
    localparam int IDX_W = SET_W + WAY_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS * WAYS - 1);
    localparam logic [WAY_W-1:0] LRU_AGE  = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;
    state_t state, state_nxt;

    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0] data_mem [SETS][WAYS];
    logic [WAYS-1:0]   valid    [SETS];
    logic [WAYS-1:0]   dirty    [SETS];
    logic [WAY_W-1:0]  age      [SETS][WAYS];

    logic [IDX_W-1:0] idx;
    logic [SET_W-1:0] scan_set;
    logic [WAY_W-1:0] scan_way;
    logic             scan_dirty;
    logic             match, victim_found;
    logic [WAY_W-1:0] match_way, victim_way, touch_way;
    logic             access, do_write, do_fill, touch;

    assign scan_set   = idx[IDX_W-1:WAY_W];
    assign scan_way   = idx[WAY_W-1:0];
    assign scan_dirty = valid[scan_set][scan_way] & dirty[scan_set][scan_way];

    always_comb begin
        match        = 1'b0;
        match_way    = '0;
        victim_found = 1'b0;
        victim_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[set_i][w] && tag_mem[set_i][w] == tag_i) begin
                match     = 1'b1;
                match_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest invalid way wins; otherwise the LRU way.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[set_i][w]) begin
                victim_found = 1'b1;
                victim_way   = WAY_W'(w);
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[set_i][w] == LRU_AGE) victim_way = WAY_W'(w);
            end
        end
    end

    assign ready_o        = (state == IDLE);
    assign hit_o          = req_i & ready_o & match;
    assign hit_way_o      = hit_o ? match_way : '0;
    assign data_o         = hit_o ? data_mem[set_i][match_way] : '0;
    assign victim_way_o   = victim_way;
    assign victim_valid_o = valid[set_i][victim_way];
    assign victim_dirty_o = dirty[set_i][victim_way];
    assign victim_tag_o   = tag_mem[set_i][victim_way];
    assign victim_data_o  = data_mem[set_i][victim_way];
    assign wb_set_o       = scan_set;
    assign wb_tag_o       = tag_mem[scan_set][scan_way];
    assign wb_data_o      = data_mem[scan_set][scan_way];

    // A flush request in the same cycle pre-empts any access.
    assign access    = rst_ni & req_i & ready_o & ~flush_i;
    assign do_write  = access & match & (we_i | fill_i);
    assign do_fill   = access & ~match & fill_i;
    assign touch     = access & (match | fill_i);
    assign touch_way = match ? match_way : victim_way;

    always_comb begin
        state_nxt    = state;
        wb_valid_o   = 1'b0;
        flush_done_o = 1'b0;
        case (state)
            IDLE: if (flush_i) state_nxt = SCAN;
            SCAN: begin
                if (scan_dirty)           state_nxt = WB;
                else if (idx == LAST_IDX) state_nxt = DONE;
            end
            WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) state_nxt = (idx == LAST_IDX) ? DONE : SCAN;
            end
            DONE: begin
                flush_done_o = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            idx   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (do_write)
                        dirty[set_i][match_way] <= dirty[set_i][match_way] | we_i | (fill_i & dirty_i);
                    if (do_fill) begin
                        valid[set_i][victim_way] <= 1'b1;
                        dirty[set_i][victim_way] <= dirty_i;
                    end
                    if (touch) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == touch_way)
                                age[set_i][w] <= '0;
                            else if (age[set_i][w] < age[set_i][touch_way])
                                age[set_i][w] <= age[set_i][w] + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (!scan_dirty) begin
                        valid[scan_set][scan_way] <= 1'b0;
                        dirty[scan_set][scan_way] <= 1'b0;
                        idx <= idx + 1'b1;
                    end
                end
                WB: begin
                    if (wb_ready_i) begin
                        valid[scan_set][scan_way] <= 1'b0;
                        dirty[scan_set][scan_way] <= 1'b0;
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    for (int s = 0; s < SETS; s++)
                        for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
                end
                default: ;
            endcase
        end
    end

    // Line payload carries no reset; validity alone decides whether it is observed.
    always_ff @(posedge clk_i) begin
        if (do_write) data_mem[set_i][match_way] <= data_i;
        if (do_fill) begin
            tag_mem[set_i][victim_way]  <= tag_i;
            data_mem[set_i][victim_way] <= data_i;
        end
    end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway: lookup, LRU victim choice, dirty eviction,
// flush write-back handshakes, clean-flush timing and reset during write-back.
module tb_dcache_sram_nway;
    logic         clk = 1'b0;
    logic         rst_ni, req_i, we_i, fill_i, dirty_i, flush_i, wb_ready_i;
    logic [3:0]   set_i;
    logic [22:0]  tag_i;
    logic [255:0] data_i;
    logic         ready_o, hit_o, victim_valid_o, victim_dirty_o, wb_valid_o, flush_done_o;
    logic [1:0]   hit_way_o, victim_way_o;
    logic [255:0] data_o, victim_data_o, wb_data_o;
    logic [22:0]  victim_tag_o, wb_tag_o;
    logic [3:0]   wb_set_o;

    int total = 0;
    int bad   = 0;
    logic [255:0] da, db, dc, d0, d1;

    always #5 clk = ~clk;

    dcache_sram_nway dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .set_i(set_i), .tag_i(tag_i),
        .we_i(we_i), .fill_i(fill_i), .dirty_i(dirty_i), .data_i(data_i),
        .ready_o(ready_o), .hit_o(hit_o), .hit_way_o(hit_way_o), .data_o(data_o),
        .victim_way_o(victim_way_o), .victim_valid_o(victim_valid_o),
        .victim_dirty_o(victim_dirty_o), .victim_tag_o(victim_tag_o),
        .victim_data_o(victim_data_o), .flush_i(flush_i), .wb_valid_o(wb_valid_o),
        .wb_ready_i(wb_ready_i), .wb_set_o(wb_set_o), .wb_tag_o(wb_tag_o),
        .wb_data_o(wb_data_o), .flush_done_o(flush_done_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic fill(input logic [3:0] s, input logic [22:0] t, input logic [255:0] d,
                        input logic dt);
        set_i = s; tag_i = t; data_i = d; dirty_i = dt; req_i = 1'b1; fill_i = 1'b1;
        tick();
        req_i = 1'b0; fill_i = 1'b0; dirty_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_i = 4'd3; tag_i = 23'h12; req_i = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", hit_o); end
        total++; if (wb_valid_o !== 1'b0 || flush_done_o !== 1'b0) begin bad++;
            $display("FAIL reset_wb got=%b%b want=00", wb_valid_o, flush_done_o); end
        total++; if (victim_way_o !== 2'd0 || victim_valid_o !== 1'b0) begin bad++;
            $display("FAIL reset_victim got=%0d/%b want=0/0", victim_way_o, victim_valid_o); end
        req_i = 1'b0;
    endtask

    task automatic test_fill_hit();
        fill(4'd3, 23'h12, da, 1'b0);
        set_i = 4'd3; tag_i = 23'h12; req_i = 1'b1;
        #1;
        total++; if (hit_o !== 1'b1 || hit_way_o !== 2'd0) begin bad++;
            $display("FAIL fill_hit got=%b/%0d want=1/0", hit_o, hit_way_o); end
        total++; if (data_o !== da) begin bad++; $display("FAIL fill_data got=%h want=%h", data_o, da); end
        tag_i = 23'h13;
        #1;
        total++; if (hit_o !== 1'b0 || hit_way_o !== 2'd0 || data_o !== 256'd0) begin bad++;
            $display("FAIL miss_out got=%b/%0d/%h want=0/0/0", hit_o, hit_way_o, data_o); end
        req_i = 1'b0;
    endtask

    task automatic test_lru();
        for (int w = 0; w < 4; w++) fill(4'd5, 23'h50 + 23'(w), dc, 1'b0);
        set_i = 4'd5; tag_i = 23'h50; req_i = 1'b1;
        tick();
        req_i = 1'b0; tag_i = 23'h77;
        #1;
        total++; if (victim_way_o !== 2'd1 || victim_valid_o !== 1'b1) begin bad++;
            $display("FAIL lru_victim got=%0d/%b want=1/1", victim_way_o, victim_valid_o); end
        total++; if (victim_tag_o !== 23'h51) begin bad++;
            $display("FAIL lru_vtag got=%h want=51", victim_tag_o); end
        fill(4'd5, 23'h60, db, 1'b0);
        set_i = 4'd5; tag_i = 23'h60; req_i = 1'b1;
        #1;
        total++; if (hit_o !== 1'b1 || hit_way_o !== 2'd1) begin bad++;
            $display("FAIL lru_refill got=%b/%0d want=1/1", hit_o, hit_way_o); end
        total++; if (victim_way_o !== 2'd2) begin bad++;
            $display("FAIL lru_next got=%0d want=2", victim_way_o); end
        req_i = 1'b0;
    endtask

    task automatic test_dirty_evict();
        fill(4'd2, 23'h20, dc, 1'b0);
        fill(4'd2, 23'h21, dc, 1'b0);
        set_i = 4'd2; tag_i = 23'h21; data_i = db; req_i = 1'b1; we_i = 1'b1;
        #1;
        total++; if (hit_o !== 1'b1 || hit_way_o !== 2'd1) begin bad++;
            $display("FAIL wr_hit got=%b/%0d want=1/1", hit_o, hit_way_o); end
        tick();
        req_i = 1'b0; we_i = 1'b0;
        fill(4'd2, 23'h22, dc, 1'b0);
        fill(4'd2, 23'h23, dc, 1'b0);
        set_i = 4'd2; tag_i = 23'h20; req_i = 1'b1;
        tick();
        req_i = 1'b0;
        #1;
        total++; if (victim_way_o !== 2'd1 || victim_dirty_o !== 1'b1) begin bad++;
            $display("FAIL ev_victim got=%0d/%b want=1/1", victim_way_o, victim_dirty_o); end
        total++; if (victim_data_o !== db || victim_tag_o !== 23'h21) begin bad++;
            $display("FAIL ev_payload got=%h/%h want=%h/21", victim_data_o, victim_tag_o, db); end
        fill(4'd2, 23'h24, dc, 1'b0);
        set_i = 4'd2; tag_i = 23'h21; req_i = 1'b1;
        #1;
        total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL ev_gone got=%b want=0", hit_o); end
        tag_i = 23'h24;
        #1;
        total++; if (hit_o !== 1'b1 || hit_way_o !== 2'd1) begin bad++;
            $display("FAIL ev_new got=%b/%0d want=1/1", hit_o, hit_way_o); end
        total++; if (victim_way_o !== 2'd2 || victim_dirty_o !== 1'b0) begin bad++;
            $display("FAIL ev_next got=%0d/%b want=2/0", victim_way_o, victim_dirty_o); end
        req_i = 1'b0;
    endtask

    task automatic test_flush_dirty();
        int n, extra, hits;
        logic seen;
        do_reset();
        fill(4'd0, 23'h00, dc, 1'b0);
        fill(4'd0, 23'h01, dc, 1'b0);
        fill(4'd0, 23'h02, d0, 1'b1);
        fill(4'd15, 23'h30, dc, 1'b0);
        fill(4'd15, 23'h31, dc, 1'b0);
        fill(4'd15, 23'h32, dc, 1'b0);
        fill(4'd15, 23'h3F, d1, 1'b1);
        wb_ready_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n = 0;
        while (!wb_valid_o && n < 200) begin tick(); n++; end
        total++; if (wb_valid_o !== 1'b1 || wb_set_o !== 4'd0 || wb_tag_o !== 23'h02 || wb_data_o !== d0) begin
            bad++; $display("FAIL wb1 got=%b/%0d/%h want=1/0/02", wb_valid_o, wb_set_o, wb_tag_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (wb_valid_o !== 1'b1 || wb_tag_o !== 23'h02 || wb_data_o !== d0 || ready_o !== 1'b0) begin
                bad++; $display("FAIL wb1_hold cyc=%0d got=%b/%h/%b want=1/02/0", i, wb_valid_o, wb_tag_o, ready_o); end
        end
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        n = 0;
        while (!wb_valid_o && n < 200) begin tick(); n++; end
        total++; if (wb_valid_o !== 1'b1 || wb_set_o !== 4'd15 || wb_tag_o !== 23'h3F || wb_data_o !== d1) begin
            bad++; $display("FAIL wb2 got=%b/%0d/%h want=1/15/3f", wb_valid_o, wb_set_o, wb_tag_o); end
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        n = 0; extra = 0; seen = 1'b0;
        while (n < 200) begin
            if (flush_done_o) begin seen = 1'b1; break; end
            if (wb_valid_o) extra++;
            tick(); n++;
        end
        total++; if (seen !== 1'b1 || extra != 0) begin bad++;
            $display("FAIL flush_done got=%b/%0d want=1/0", seen, extra); end
        tick();
        total++; if (flush_done_o !== 1'b0 || ready_o !== 1'b1) begin bad++;
            $display("FAIL done_pulse got=%b/%b want=0/1", flush_done_o, ready_o); end
        hits = 0;
        req_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_i = (i < 3) ? 4'd0 : 4'd15;
            tag_i = (i < 3) ? 23'(i) : ((i == 6) ? 23'h3F : 23'h30 + 23'(i - 3));
            #1;
            if (hit_o) hits++;
        end
        req_i = 1'b0;
        total++; if (hits != 0) begin bad++; $display("FAIL post_flush_hits got=%0d want=0", hits); end
    endtask

    task automatic test_flush_clean();
        int n, wbs, dones;
        fill(4'd7, 23'h70, dc, 1'b0);
        set_i = 4'd9; tag_i = 23'h99; data_i = da; req_i = 1'b1; fill_i = 1'b1; flush_i = 1'b1;
        tick();
        req_i = 1'b0; fill_i = 1'b0; flush_i = 1'b0;
        n = 0; wbs = 0; dones = 0;
        while (!ready_o && n < 500) begin
            if (wb_valid_o) wbs++;
            if (flush_done_o) dones++;
            tick(); n++;
        end
        total++; if (n != 65) begin bad++; $display("FAIL clean_busy got=%0d want=65", n); end
        total++; if (wbs != 0 || dones != 1) begin bad++;
            $display("FAIL clean_wb got=%0d/%0d want=0/1", wbs, dones); end
        req_i = 1'b1; set_i = 4'd7; tag_i = 23'h70;
        #1;
        total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL clean_inval got=%b want=0", hit_o); end
        set_i = 4'd9; tag_i = 23'h99;
        #1;
        total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL flush_prio got=%b want=0", hit_o); end
        req_i = 1'b0;
    endtask

    task automatic test_reset_mid_wb();
        int n;
        fill(4'd4, 23'h44, da, 1'b1);
        fill(4'd3, 23'h12, da, 1'b0);
        wb_ready_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n = 0;
        while (!wb_valid_o && n < 200) begin tick(); n++; end
        total++; if (wb_valid_o !== 1'b1 || wb_set_o !== 4'd4) begin bad++;
            $display("FAIL rst_wb_pre got=%b/%0d want=1/4", wb_valid_o, wb_set_o); end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        total++; if (wb_valid_o !== 1'b0 || ready_o !== 1'b1) begin bad++;
            $display("FAIL rst_wb_drop got=%b/%b want=0/1", wb_valid_o, ready_o); end
        req_i = 1'b1; set_i = 4'd4; tag_i = 23'h44;
        #1;
        total++; if (hit_o !== 1'b0 || victim_valid_o !== 1'b0) begin bad++;
            $display("FAIL rst_miss4 got=%b/%b want=0/0", hit_o, victim_valid_o); end
        set_i = 4'd3; tag_i = 23'h12;
        #1;
        total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL rst_miss3 got=%b want=0", hit_o); end
        req_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; fill_i = 1'b0; dirty_i = 1'b0;
        flush_i = 1'b0; wb_ready_i = 1'b0; set_i = '0; tag_i = '0; data_i = '0;
        da = {8{32'hA5A5_0003}};
        db = {8{32'hB00B_0002}};
        dc = {8{32'hC0DE_0007}};
        d0 = {8{32'hD000_0002}};
        d1 = {8{32'hD111_003F}};
        test_reset();
        test_fill_hit();
        test_lru();
        test_dirty_evict();
        test_flush_dirty();
        test_flush_clean();
        test_reset_mid_wb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
